// File: rtl/fibo_pkg.sv
// Shared types and constants for the generalised Fibonacci generator.
package fibo_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOp,
        StDone
    } state_e;

    // Overflow policy encodings for the SAT parameter.
    localparam int unsigned SatWrap  = 0;
    localparam int unsigned SatClamp = 1;

endpackage

// File: rtl/sat_add.sv
// W-bit adder with carry out; optionally clamps to all-ones once an overflow has been seen.
module sat_add
    import fibo_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned SAT = SatWrap
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ovf_in,
    output logic [W-1:0] y,
    output logic         carry
);

    localparam logic [W-1:0] AllOnes = '1;

    logic [W:0] sum;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign carry = sum[W];

    // Once saturated, stay saturated even if a later wrapped sum would not carry.
    always_comb begin
        y = sum[W-1:0];
        if (SAT == SatClamp && (carry || ovf_in)) begin
            y = AllOnes;
        end
    end

endmodule

// File: rtl/fibo_gen.sv
// Iterative generalised Fibonacci generator: f(i) from seeds f(0), f(1) with start/ready/done_tick.
module fibo_gen
    import fibo_pkg::*;
#(
    parameter int unsigned W   = 32,
    parameter int unsigned NW  = 6,
    parameter int unsigned SAT = SatWrap
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [NW-1:0] i,
    input  logic [W-1:0]  seed0,
    input  logic [W-1:0]  seed1,
    output logic          ready,
    output logic          done_tick,
    output logic          ovf,
    output logic [W-1:0]  f
);

    state_e        state_q, state_d;
    logic [W-1:0]  t0_q, t0_d;
    logic [W-1:0]  t1_q, t1_d;
    logic [NW-1:0] n_q, n_d;
    logic          ovf_q, ovf_d;

    logic [W-1:0]  add_y;
    logic          add_carry;

    sat_add #(
        .W   (W),
        .SAT (SAT)
    ) u_sat_add (
        .a      (t0_q),
        .b      (t1_q),
        .ovf_in (ovf_q),
        .y      (add_y),
        .carry  (add_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            t0_q    <= '0;
            t1_q    <= '0;
            n_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            n_q     <= n_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        n_d     = n_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    t0_d    = seed0;
                    t1_d    = seed1;
                    n_d     = i;
                    ovf_d   = 1'b0;
                    state_d = StOp;
                end
            end
            StOp: begin
                // Abort leaves the datapath untouched so f shows the partial result.
                if (abort) begin
                    state_d = StIdle;
                end else if (n_q == '0) begin
                    t1_d    = t0_q;
                    state_d = StDone;
                end else if (n_q == NW'(1)) begin
                    state_d = StDone;
                end else begin
                    t0_d  = t1_q;
                    t1_d  = add_y;
                    n_d   = n_q - NW'(1);
                    ovf_d = ovf_q | add_carry;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready     = (state_q == StIdle);
    assign done_tick = (state_q == StDone);
    assign f         = t1_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fibo_gen.sv
// Directed bench for fibo_gen: W=20 wrap, W=8 wrap and W=8 saturating instances on one clock.
module tb_fibo_gen;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [5:0]  i;
    logic [19:0] seed0, seed1;
    int          sel;

    logic        start_20, start_8w, start_8s;
    logic        rdy_20, rdy_8w, rdy_8s;
    logic        dn_20, dn_8w, dn_8s;
    logic        ov_20, ov_8w, ov_8s;
    logic [19:0] f_20;
    logic [7:0]  f_8w, f_8s;

    logic        cur_ready, cur_done, cur_ovf;
    logic [19:0] cur_f;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign start_20 = start && (sel == 0);
    assign start_8w = start && (sel == 1);
    assign start_8s = start && (sel == 2);

    always_comb begin
        cur_ready = rdy_20;
        cur_done  = dn_20;
        cur_ovf   = ov_20;
        cur_f     = f_20;
        if (sel == 1) begin
            cur_ready = rdy_8w; cur_done = dn_8w; cur_ovf = ov_8w; cur_f = {12'b0, f_8w};
        end else if (sel == 2) begin
            cur_ready = rdy_8s; cur_done = dn_8s; cur_ovf = ov_8s; cur_f = {12'b0, f_8s};
        end
    end

    fibo_gen #(.W(20), .NW(6), .SAT(0)) u_w20 (
        .clk(clk), .rst_n(rst_n), .start(start_20), .abort(abort), .i(i),
        .seed0(seed0), .seed1(seed1), .ready(rdy_20), .done_tick(dn_20), .ovf(ov_20), .f(f_20)
    );

    fibo_gen #(.W(8), .NW(6), .SAT(0)) u_w8_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_8w), .abort(abort), .i(i),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .ready(rdy_8w), .done_tick(dn_8w),
        .ovf(ov_8w), .f(f_8w)
    );

    fibo_gen #(.W(8), .NW(6), .SAT(1)) u_w8_sat (
        .clk(clk), .rst_n(rst_n), .start(start_8s), .abort(abort), .i(i),
        .seed0(seed0[7:0]), .seed1(seed1[7:0]), .ready(rdy_8s), .done_tick(dn_8s),
        .ovf(ov_8s), .f(f_8s)
    );

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle
    // after done_tick, so consecutive calls are back-to-back.
    // lat counts cycles from the start cycle to the done_tick cycle (0 on timeout).
    task automatic run(input int s, input logic [5:0] idx, input logic [19:0] a,
                       input logic [19:0] b, output int lat, output logic [19:0] fo,
                       output logic ov, output logic busy_ready, output logic post_done,
                       output logic post_ready);
        sel = s; i = idx; seed0 = a; seed1 = b; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0; busy_ready = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) busy_ready = cur_ready;
            if (cur_done) begin
                lat = c;
                break;
            end
        end
        fo = cur_f; ov = cur_ovf;
        @(negedge clk);
        post_done = cur_done; post_ready = cur_ready;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (rdy_20 !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", rdy_20); end
        n_cmp++; if (dn_20 !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", dn_20); end
        n_cmp++; if (f_20 !== 20'd0) begin n_bad++; $display("FAIL rst_f: got %0d want 0", f_20); end
        n_cmp++; if (ov_20 !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", ov_20); end
        n_cmp++; if ({rdy_8s, dn_8s, ov_8s, f_8s} !== {3'b100, 8'd0}) begin
            n_bad++; $display("FAIL rst_w8sat: got %b%b%b/%0d want 100/0", rdy_8s, dn_8s, ov_8s, f_8s);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fib();
        int lat; logic [19:0] fo; logic ov, br, pd, pr;
        run(0, 6'd10, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd55) begin n_bad++; $display("FAIL fib10_f: got %0d want 55", fo); end
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL fib10_ovf: got %b want 0", ov); end
        n_cmp++; if (lat !== 11) begin n_bad++; $display("FAIL fib10_lat: got %0d want 11", lat); end
        n_cmp++; if (br !== 1'b0) begin n_bad++; $display("FAIL fib10_busy_ready: got %b want 0", br); end
        n_cmp++; if (pd !== 1'b0) begin n_bad++; $display("FAIL fib10_done_width: got %b want 0", pd); end
        n_cmp++; if (pr !== 1'b1) begin n_bad++; $display("FAIL fib10_ready_after: got %b want 1", pr); end
        // back-to-back runs
        run(0, 6'd0, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd0) begin n_bad++; $display("FAIL fib0_f: got %0d want 0", fo); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL fib0_lat: got %0d want 2", lat); end
        run(0, 6'd1, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd1) begin n_bad++; $display("FAIL fib1_f: got %0d want 1", fo); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL fib1_lat: got %0d want 2", lat); end
    endtask

    task automatic test_lucas();
        int lat; logic [19:0] fo; logic ov, br, pd, pr;
        run(0, 6'd5, 20'd2, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd11) begin n_bad++; $display("FAIL lucas5_f: got %0d want 11", fo); end
        n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL lucas5_lat: got %0d want 6", lat); end
        run(0, 6'd0, 20'd2, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd2) begin n_bad++; $display("FAIL lucas0_f: got %0d want 2", fo); end
        n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL lucas0_lat: got %0d want 2", lat); end
    endtask

    task automatic test_wrap();
        int lat; logic [19:0] fo; logic ov, br, pd, pr;
        run(1, 6'd13, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd233) begin n_bad++; $display("FAIL wrap13_f: got %0d want 233", fo); end
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL wrap13_ovf: got %b want 0", ov); end
        run(1, 6'd14, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd121) begin n_bad++; $display("FAIL wrap14_f: got %0d want 121", fo); end
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL wrap14_ovf: got %b want 1", ov); end
        n_cmp++; if (lat !== 15) begin n_bad++; $display("FAIL wrap14_lat: got %0d want 15", lat); end
    endtask

    task automatic test_sat();
        int lat; logic [19:0] fo; logic ov, br, pd, pr;
        run(2, 6'd14, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd255) begin n_bad++; $display("FAIL sat14_f: got %0d want 255", fo); end
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL sat14_ovf: got %b want 1", ov); end
        run(2, 6'd16, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd255) begin n_bad++; $display("FAIL sat16_f: got %0d want 255", fo); end
        n_cmp++; if (ov !== 1'b1) begin n_bad++; $display("FAIL sat16_ovf: got %b want 1", ov); end
    endtask

    task automatic test_abort();
        int lat; logic [19:0] fo; logic ov, br, pd, pr, seen;
        sel = 0; i = 6'd20; seed0 = 20'd0; seed1 = 20'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1; i = 6'd3;
        @(posedge clk); #1 start = 1'b0; abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdy_20 !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %b want 1", rdy_20); end
        n_cmp++; if (dn_20 !== 1'b0) begin n_bad++; $display("FAIL abort_done: got %b want 0", dn_20); end
        n_cmp++; if (f_20 !== 20'd2) begin n_bad++; $display("FAIL abort_partial_f: got %0d want 2", f_20); end
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (dn_20) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %b want 0", seen); end
        run(0, 6'd7, 20'd0, 20'd1, lat, fo, ov, br, pd, pr);
        n_cmp++; if (fo !== 20'd13) begin n_bad++; $display("FAIL after_abort_f: got %0d want 13", fo); end
        n_cmp++; if (ov !== 1'b0) begin n_bad++; $display("FAIL after_abort_ovf: got %b want 0", ov); end
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL after_abort_lat: got %0d want 8", lat); end
    endtask

    task automatic test_reset_midrun();
        logic seen;
        sel = 0; i = 6'd30; seed0 = 20'd0; seed1 = 20'd1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if ({rdy_20, dn_20, ov_20} !== 3'b100) begin
                n_bad++; $display("FAIL midrst_flags[%0d]: got rdy/done/ovf %b%b%b want 100", k, rdy_20, dn_20, ov_20);
            end
            n_cmp++; if (f_20 !== 20'd0) begin n_bad++; $display("FAIL midrst_f[%0d]: got %0d want 0", k, f_20); end
            n_cmp++; if ({ov_8s, f_8s} !== 9'd0) begin
                n_bad++; $display("FAIL midrst_w8sat[%0d]: got ovf %b f %0d want 0/0", k, ov_8s, f_8s);
            end
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (dn_20) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL midrst_no_done: got %b want 0", seen); end
        n_cmp++; if (rdy_20 !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", rdy_20); end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 0;
        i = '0; seed0 = '0; seed1 = '0;
        test_reset();
        test_fib();
        test_lucas();
        test_wrap();
        test_sat();
        test_abort();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
